// File: rtl/flag_register.sv
// flag_register: architectural {N,V,Z} flags written from the EX stage.
// Opcode decides which flag bits a commit may touch; stall holds a pending
// writer in EX, flush squashes it, and reset discards whatever is in EX.
// F_fwd is the value F takes at the coming edge, so dependent logic can
// consume flags in the same cycle as the writer commits.
module flag_register (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [3:0]  ex_opcode,
  input  logic [15:0] alu_result,
  input  logic        alu_ovfl,
  input  logic        stall,
  input  logic        flush,
  output logic [2:0]  F,
  output logic [2:0]  F_fwd,
  output logic        flag_busy,
  output logic [7:0]  wr_cnt
);

  // Bit positions within the {N,V,Z} flag vector.
  localparam logic [2:0] MASK_NVZ  = 3'b111;
  localparam logic [2:0] MASK_Z    = 3'b001;
  localparam logic [2:0] MASK_NONE = 3'b000;

  logic [2:0] f_q, f_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] wr_mask;
  logic [2:0] cand;
  logic       writer;
  logic       commit;

  // Per-opcode write enable mask; unknown opcodes fall to "no write".
  always_comb begin
    wr_mask = MASK_NONE;
    case (ex_opcode)
      4'b0000, 4'b0001:                   wr_mask = MASK_NVZ; // ADD, SUB
      4'b0010, 4'b0100, 4'b0101, 4'b0110: wr_mask = MASK_Z;   // XOR, SLL, SRA, ROR
      default:                            wr_mask = MASK_NONE;
    endcase
  end

  assign writer = |wr_mask;
  assign cand   = {alu_result[15], alu_ovfl, (alu_result == 16'h0000)};

  // ex_valid gates everything so a bubble's opcode bits never matter.
  assign commit    = ex_valid & ~stall & ~flush & writer;
  assign flag_busy = ex_valid &  stall & ~flush & writer;

  // Next flag/counter state: reset wins, then a commit merges enabled bits.
  always_comb begin
    f_d   = f_q;
    cnt_d = cnt_q;
    if (rst) begin
      f_d   = 3'b000;
      cnt_d = 8'h00;
    end else if (commit) begin
      f_d   = (cand & wr_mask) | (f_q & ~wr_mask);
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Flag and commit-counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_q   <= 3'b000;
      cnt_q <= 8'h00;
    end else begin
      f_q   <= f_d;
      cnt_q <= cnt_d;
    end
  end

  assign F      = f_q;
  assign F_fwd  = f_d;
  assign wr_cnt = cnt_q;

endmodule

// File: tb/tb_flag_register.sv
// tb_flag_register: scoreboard bench for flag_register. Each driven cycle
// pushes the expected post-edge {F,wr_cnt} into a queue; it is popped and
// compared one cycle later. Combinational outputs are checked mid-cycle.
module tb_flag_register;

  logic        clk = 1'b0;
  logic        rst, ex_valid, alu_ovfl, stall, flush;
  logic [3:0]  ex_opcode;
  logic [15:0] alu_result;
  logic [2:0]  F, F_fwd;
  logic        flag_busy;
  logic [7:0]  wr_cnt;

  flag_register dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .alu_result(alu_result), .alu_ovfl(alu_ovfl), .stall(stall), .flush(flush),
    .F(F), .F_fwd(F_fwd), .flag_busy(flag_busy), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [2:0] f; logic [7:0] cnt; } exp_t;
  exp_t       sb[$];
  exp_t       e;
  logic [2:0] mf = 3'b000;
  logic [7:0] mcnt = 8'h00;
  logic [2:0] exp_fwd;
  logic       exp_busy;
  int         total = 0;
  int         bad = 0;

  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, XOR = 4'b0010;
  localparam logic [3:0] PADDSB = 4'b0111;

  // Drive one EX cycle and push the expected architectural state after the edge.
  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                       input logic ov, input logic st, input logic fl, input logic r);
    logic [2:0] m, c, nf;
    logic [7:0] nc;
    logic       com;
    ex_valid = v; ex_opcode = op; alu_result = res; alu_ovfl = ov;
    stall = st; flush = fl; rst = r;
    case (op)
      4'd0, 4'd1:             m = 3'b111;
      4'd2, 4'd4, 4'd5, 4'd6: m = 3'b001;
      default:                m = 3'b000;
    endcase
    c   = {res[15], ov, res == 16'h0};
    com = v && !st && !fl && (m != 3'b000);
    exp_busy = v && st && !fl && (m != 3'b000);
    nf = mf; nc = mcnt;
    if (r) begin nf = 3'b000; nc = 8'h00; end
    else if (com) begin nf = (c & m) | (mf & ~m); nc = mcnt + 8'd1; end
    exp_fwd = nf;
    sb.push_back('{f: nf, cnt: nc});
    mf = nf; mcnt = nc;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    drive(1'b1, ADD, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1);
    #3;
    total++; if (F_fwd !== 3'b000) begin bad++; $display("FAIL rst_fwd: got %b want 000", F_fwd); end
    tick(); e = sb.pop_front();
    total++; if (F !== 3'b000 || wr_cnt !== 8'h00) begin bad++; $display("FAIL rst_state: got F=%b cnt=%h want 000/00", F, wr_cnt); end
    // stalled writer during reset still reports busy
    drive(1'b1, SUB, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
    #3;
    total++; if (flag_busy !== 1'b1 || F_fwd !== 3'b000) begin bad++; $display("FAIL rst_busy: got busy=%b fwd=%b want 1/000", flag_busy, F_fwd); end
    tick(); e = sb.pop_front();
    total++; if (F !== e.f || wr_cnt !== e.cnt) begin bad++; $display("FAIL rst_hold: got %b/%h want %b/%h", F, wr_cnt, e.f, e.cnt); end
  endtask

  task automatic test_full_write;
    drive(1'b1, ADD, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0);
    #3;
    total++; if (F_fwd !== 3'b110) begin bad++; $display("FAIL add_fwd: got %b want 110", F_fwd); end
    tick(); e = sb.pop_front();
    total++; if (F !== 3'b110 || wr_cnt !== 8'd1 || F !== e.f) begin bad++; $display("FAIL add_commit: got F=%b cnt=%0d want 110/1", F, wr_cnt); end
  endtask

  task automatic test_z_only;
    drive(1'b1, XOR, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    total++; if (F_fwd !== 3'b111) begin bad++; $display("FAIL xor_fwd: got %b want 111", F_fwd); end
    tick(); e = sb.pop_front();
    total++; if (F !== 3'b111 || wr_cnt !== e.cnt) begin bad++; $display("FAIL xor_commit: got F=%b cnt=%0d want 111/%0d", F, wr_cnt, e.cnt); end
  endtask

  task automatic test_nonwriter;
    drive(1'b1, SUB, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); e = sb.pop_front();
    total++; if (F !== 3'b001 || wr_cnt !== e.cnt) begin bad++; $display("FAIL set001: got F=%b cnt=%0d want 001/%0d", F, wr_cnt, e.cnt); end
    foreach (sb[i]) ; // queue must be empty here
    for (int op = 0; op < 16; op++) begin
      logic [3:0] o;
      o = 4'(op);
      if (o inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6}) continue;
      drive(1'b1, o, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0);
      #3;
      total++; if (F_fwd !== 3'b001 || flag_busy !== 1'b0) begin bad++; $display("FAIL nonwr_fwd op=%h: got fwd=%b busy=%b want 001/0", o, F_fwd, flag_busy); end
      tick(); e = sb.pop_front();
      total++; if (F !== 3'b001 || wr_cnt !== e.cnt) begin bad++; $display("FAIL nonwr op=%h: got F=%b cnt=%0d want 001/%0d", o, F, wr_cnt, e.cnt); end
    end
  endtask

  task automatic test_stall;
    drive(1'b1, ADD, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); e = sb.pop_front();
    total++; if (F !== 3'b110) begin bad++; $display("FAIL stall_pre: got %b want 110", F); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, SUB, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
      #3;
      total++; if (flag_busy !== 1'b1 || F_fwd !== 3'b110) begin bad++; $display("FAIL stall_busy%0d: got busy=%b fwd=%b want 1/110", i, flag_busy, F_fwd); end
      tick(); e = sb.pop_front();
      total++; if (F !== 3'b110 || wr_cnt !== e.cnt) begin bad++; $display("FAIL stall_hold%0d: got F=%b cnt=%0d want 110/%0d", i, F, wr_cnt, e.cnt); end
    end
    drive(1'b1, SUB, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    total++; if (F_fwd !== 3'b001 || flag_busy !== 1'b0) begin bad++; $display("FAIL stall_rel_fwd: got fwd=%b busy=%b want 001/0", F_fwd, flag_busy); end
    tick(); e = sb.pop_front();
    total++; if (F !== 3'b001 || wr_cnt !== e.cnt) begin bad++; $display("FAIL stall_rel: got F=%b cnt=%0d want 001/%0d", F, wr_cnt, e.cnt); end
  endtask

  task automatic test_flush;
    drive(1'b1, ADD, 16'h8000, 1'b1, 1'b1, 1'b1, 1'b0);
    #3;
    total++; if (flag_busy !== 1'b0 || F_fwd !== 3'b001) begin bad++; $display("FAIL flush_st: got busy=%b fwd=%b want 0/001", flag_busy, F_fwd); end
    tick(); e = sb.pop_front();
    total++; if (F !== 3'b001 || wr_cnt !== e.cnt) begin bad++; $display("FAIL flush_st_state: got F=%b cnt=%0d want 001/%0d", F, wr_cnt, e.cnt); end
    drive(1'b1, SUB, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(); e = sb.pop_front();
    total++; if (F !== 3'b001 || wr_cnt !== e.cnt) begin bad++; $display("FAIL flush: got F=%b cnt=%0d want 001/%0d", F, wr_cnt, e.cnt); end
    // bubble with undefined opcode changes nothing
    drive(1'b0, 4'bxxxx, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0);
    #3;
    total++; if (flag_busy !== 1'b0 || F_fwd !== 3'b001) begin bad++; $display("FAIL bubble_x: got busy=%b fwd=%b want 0/001", flag_busy, F_fwd); end
    tick(); e = sb.pop_front();
    total++; if (F !== 3'b001 || wr_cnt !== e.cnt) begin bad++; $display("FAIL bubble_state: got F=%b cnt=%0d want 001/%0d", F, wr_cnt, e.cnt); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 40; i++) begin
      logic [3:0]  o;
      logic [15:0] r;
      o = 4'($urandom_range(0, 7));
      r = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      drive(1'b1, o, r, 1'($urandom), 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 5) == 0), 1'b0);
      #3;
      total++; if (F_fwd !== exp_fwd || flag_busy !== exp_busy) begin bad++; $display("FAIL b2b_fwd%0d: got fwd=%b busy=%b want %b/%b", i, F_fwd, flag_busy, exp_fwd, exp_busy); end
      tick(); e = sb.pop_front();
      total++; if (F !== e.f || wr_cnt !== e.cnt) begin bad++; $display("FAIL b2b%0d: got %b/%h want %b/%h", i, F, wr_cnt, e.f, e.cnt); end
    end
  endtask

  task automatic test_wrap_reset;
    drive(1'b0, ADD, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); e = sb.pop_front();
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, ADD, 16'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0);
      tick(); e = sb.pop_front();
      total++; if (F !== e.f || wr_cnt !== e.cnt) begin bad++; $display("FAIL wrap%0d: got %b/%h want %b/%h", i, F, wr_cnt, e.f, e.cnt); end
    end
    total++; if (wr_cnt !== 8'h00) begin bad++; $display("FAIL wrap_zero: got %h want 00", wr_cnt); end
    drive(1'b1, SUB, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1);
    #3;
    total++; if (F_fwd !== 3'b000) begin bad++; $display("FAIL rst_commit_fwd: got %b want 000", F_fwd); end
    tick(); e = sb.pop_front();
    total++; if (F !== 3'b000 || wr_cnt !== 8'h00) begin bad++; $display("FAIL rst_commit: got %b/%h want 000/00", F, wr_cnt); end
    drive(1'b1, PADDSB, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); e = sb.pop_front();
    drive(1'b1, SUB, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); e = sb.pop_front();
    total++; if (F !== 3'b001 || wr_cnt !== 8'h01) begin bad++; $display("FAIL first_commit: got %b/%h want 001/01", F, wr_cnt); end
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_z_only();
    test_nonwriter();
    test_stall();
    test_flush();
    test_back_to_back();
    test_wrap_reset();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_drain: got %0d want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flag_register.md
FLAG_REGISTER -- requirements
Module: flag_register

Interface
- REQ-001: The block SHALL have a `clk` input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-002: The block SHALL have a `rst` input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
- REQ-003: The block SHALL have an `ex_valid` input, 1 bit: the EX stage holds a real (non-bubble) instruction.
- REQ-004: The block SHALL have an `ex_opcode` input, 4 bits: opcode of the EX-stage instruction.
- REQ-005: The block SHALL have an `alu_result` input, 16 bits: ALU output for the EX instruction.
- REQ-006: The block SHALL have an `alu_ovfl` input, 1 bit: signed overflow from the ALU adder for the EX instruction.
- REQ-007: The block SHALL have a `stall` input, 1 bit: the pipeline holds EX this cycle; the instruction is not retired from EX.
- REQ-008: The block SHALL have a `flush` input, 1 bit: the EX instruction is squashed this cycle.
- REQ-009: The block SHALL have an `F` output, 3 bits: architectural flags, registered, encoded as {N,V,Z}.
- REQ-010: The block SHALL have an `F_fwd` output, 3 bits: forwarded flags {N,V,Z}, equal to the value F will hold after this edge.
- REQ-011: The block SHALL have a `flag_busy` output, 1 bit: a flag writer sits in EX but cannot commit this cycle.
- REQ-012: The block SHALL have a `wr_cnt` output, 8 bits: count of committed flag-writing instructions, for debug.

Function
- REQ-013: The block SHALL classify ex_opcode 0000 (ADD) and 0001 (SUB) as writers of N, V and Z.
- REQ-014: The block SHALL classify ex_opcode 0010 (XOR), 0100 (SLL), 0101 (SRA) and 0110 (ROR) as writers of Z only.
- REQ-015: The block SHALL treat every other opcode, including RED and PADDSB, as a non-writer that leaves all flags unchanged.
- REQ-016: The block SHALL compute the candidate flags as Z = (alu_result == 16'h0000), N = alu_result[15], V = alu_ovfl.
- REQ-017: The block SHALL commit a write only when ex_valid=1, stall=0, flush=0 and the opcode is a writer.
- REQ-018: On commit, the block SHALL update only the bits enabled for that opcode; non-enabled bits SHALL retain their old values.
- REQ-019: Committed flags SHALL appear on F on the cycle after the commit edge, i.e. one-cycle latency.
- REQ-020: F_fwd SHALL be combinational: it SHALL equal the merged new value when a commit condition holds, and F otherwise.
- REQ-021: flag_busy SHALL equal ex_valid & stall & ~flush & writer(ex_opcode).
- REQ-022: flag_busy SHALL be combinational and SHALL depend on no other state.
- REQ-023: When stall=1, F SHALL hold its value and the pending writer SHALL commit on the first cycle stall deasserts (provided flush=0).
- REQ-024: flush SHALL take priority over stall and commit; a flushed writer SHALL never modify F or wr_cnt.
- REQ-025: wr_cnt SHALL increment by 1 on each commit and wrap from 8'hFF to 8'h00.
- REQ-026: wr_cnt SHALL NOT increment on stalled, flushed, invalid or non-writer cycles.
- REQ-027: On back-to-back commits, each cycle's write SHALL land in order; F_fwd SHALL reflect the youngest writer.
- REQ-028: X or Z on ex_opcode SHALL be irrelevant when ex_valid=0; the block SHALL NOT update state in that case.

Reset
- REQ-029: When rst=1 at an edge, the block SHALL set F to 3'b000 and wr_cnt to 8'h00.
- REQ-030: rst SHALL override any simultaneous commit; the writer in EX on the reset edge SHALL be discarded.
- REQ-031: During rst=1, F_fwd SHALL equal 3'b000 and flag_busy SHALL follow REQ-021.
- REQ-032: After rst deasserts, the first commit SHALL be the first valid non-stalled, non-flushed writer.

Verification
- REQ-033: The bench SHALL apply ADD with alu_result=16'h8000 and alu_ovfl=1 -> F_fwd=3'b110 in that cycle, then F=3'b110 and wr_cnt=1 on the next cycle.
- REQ-034: The bench SHALL set F=3'b110, then apply XOR with alu_result=16'h0000 -> F=3'b111 (N and V kept, Z set).
- REQ-035: The bench SHALL set F=3'b001, then apply PADDSB with alu_result=16'h8000 -> F stays 3'b001 and wr_cnt is unchanged.
- REQ-036: The bench SHALL apply SUB with alu_result=0 under stall=1 for 3 cycles -> flag_busy=1 for 3 cycles and F unchanged; on the stall release cycle F_fwd=3'b001, then F=3'b001.
- REQ-037: The bench SHALL apply ADD with flush=1 and stall=1 together -> flag_busy=0, F unchanged, wr_cnt unchanged.
- REQ-038: The bench SHALL drive 256 consecutive ADD commits, then assert rst concurrently with a SUB commit -> wr_cnt wraps to 8'h00 after the 256th commit, and after reset F=3'b000 and wr_cnt=8'h00.
